// File: rtl/nois_system_pkg.sv
// Shared types and constants for the nois_system fabric masters.
// Includes the copy-engine state encoding and the Avalon word/byte address helpers.
package nois_system_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      FIN
   } state_e;

   localparam logic [3:0]  BYTE_EN_ALL = 4'b1111;
   localparam int unsigned ADDR_SHIFT  = 2;

endpackage

// File: rtl/nois_system_mem_copy_master_if.sv
// Avalon-MM bus bundle between the copy master and an on-chip memory slave.
// The master drives requests; the slave drives the stall and the read-data return.
interface nois_system_mem_copy_master_if
   import nois_system_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int BADDR_W = 17
) ();

   logic [BADDR_W-1:0]            address;
   logic                          read;
   logic                          write;
   logic [$bits(BYTE_EN_ALL)-1:0] byteenable;
   logic [DATA_W-1:0]             writedata;
   logic [DATA_W-1:0]             readdata;
   logic                          readdatavalid;
   logic                          waitrequest;

   modport master (
      output address, read, write, byteenable, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output readdata, readdatavalid, waitrequest
   );

endinterface

// File: rtl/nois_system_mem_copy_master.sv
// Avalon-MM block-copy master: reads one word from src, writes it to dst, repeats len times,
// then pulses done. Only one bus transfer is ever outstanding, so reads and writes never overlap.
module nois_system_mem_copy_master
   import nois_system_pkg::*;
#(
   parameter int WADDR_W = 15,
   parameter int DATA_W  = 32,
   parameter int BADDR_W = 17
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [WADDR_W-1:0]            src_word,
   input  logic [WADDR_W-1:0]            dst_word,
   input  logic [WADDR_W-1:0]            len_words,
   output logic                          busy,
   output logic                          done,
   output logic [WADDR_W-1:0]            words_done,
   nois_system_mem_copy_master_if.master avm
);

   localparam logic [WADDR_W-1:0] ONE = WADDR_W'(1);

   state_e                        state_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          read_q;
   logic                          write_q;
   logic [$bits(BYTE_EN_ALL)-1:0] be_q;
   logic [BADDR_W-1:0]            addr_q;
   logic [DATA_W-1:0]             data_q;
   logic [WADDR_W-1:0]            src_q;
   logic [WADDR_W-1:0]            dst_q;
   logic [WADDR_W-1:0]            len_q;
   logic [WADDR_W-1:0]            words_done_q;

   function automatic logic [BADDR_W-1:0] byte_addr(input logic [WADDR_W-1:0] word);
      return BADDR_W'(word) << ADDR_SHIFT;
   endfunction

   // Every bus output is a flop, so requests stay frozen while the slave stalls.
   // NOTE: state is updated with <= only; blocking assignments here would let later
   // statements in the same edge see half-updated values and break simulation/synthesis match.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         be_q         <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         src_q        <= '0;
         dst_q        <= '0;
         len_q        <= '0;
         words_done_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  src_q        <= src_word;
                  dst_q        <= dst_word;
                  len_q        <= len_words;
                  words_done_q <= '0;
                  busy_q       <= 1'b1;
                  if (len_words == '0) begin
                     state_q <= FIN;
                  end else begin
                     state_q <= RD_REQ;
                     read_q  <= 1'b1;
                     be_q    <= BYTE_EN_ALL;
                     addr_q  <= byte_addr(src_word);
                  end
               end
            end
            RD_REQ: begin
               if (!avm.waitrequest) begin
                  state_q <= RD_WAIT;
                  read_q  <= 1'b0;
                  be_q    <= '0;
               end
            end
            // Data valid in the acceptance cycle is never seen: we only look here.
            RD_WAIT: begin
               if (avm.readdatavalid) begin
                  state_q <= WR_REQ;
                  write_q <= 1'b1;
                  be_q    <= BYTE_EN_ALL;
                  addr_q  <= byte_addr(dst_q);
                  data_q  <= avm.readdata;
               end
            end
            WR_REQ: begin
               if (!avm.waitrequest) begin
                  write_q      <= 1'b0;
                  be_q         <= '0;
                  src_q        <= src_q + ONE;
                  dst_q        <= dst_q + ONE;
                  words_done_q <= words_done_q + ONE;
                  if ((words_done_q + ONE) == len_q) begin
                     state_q <= FIN;
                  end else begin
                     state_q <= RD_REQ;
                     read_q  <= 1'b1;
                     be_q    <= BYTE_EN_ALL;
                     addr_q  <= byte_addr(src_q + ONE);
                  end
               end
            end
            FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign words_done     = words_done_q;
   assign avm.address    = addr_q;
   assign avm.read       = read_q;
   assign avm.write      = write_q;
   assign avm.byteenable = be_q;
   assign avm.writedata  = data_q;

endmodule

// File: tb/tb_nois_system_mem_copy_master.sv
// Self-checking bench: a behavioural Avalon memory slave with random stalls and read latency,
// and a word-level copy model that predicts the final memory image and bus address sequences.
module tb_nois_system_mem_copy_master;

   localparam int WADDR_W = 15;
   localparam int DATA_W  = 32;
   localparam int BADDR_W = 17;
   localparam int MEM_N   = 32768;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic [WADDR_W-1:0] src_word = '0;
   logic [WADDR_W-1:0] dst_word = '0;
   logic [WADDR_W-1:0] len_words = '0;
   logic               busy;
   logic               done;
   logic [WADDR_W-1:0] words_done;

   nois_system_mem_copy_master_if #(.DATA_W(DATA_W), .BADDR_W(BADDR_W)) avm_if ();

   nois_system_mem_copy_master #(
      .WADDR_W(WADDR_W), .DATA_W(DATA_W), .BADDR_W(BADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_word   (src_word),
      .dst_word   (dst_word),
      .len_words  (len_words),
      .busy       (busy),
      .done       (done),
      .words_done (words_done),
      .avm        (avm_if)
   );

   always #5 clk = ~clk;

   int                checks = 0;
   int                errors = 0;
   int                stall_pct = 0;
   int                lat_max = 1;
   bit                stall_writes = 1'b0;
   int                req_cycles = 0;
   logic [DATA_W-1:0] mem     [MEM_N];
   logic [DATA_W-1:0] exp_mem [MEM_N];
   logic [16:0]       rd_log[$];
   logic [16:0]       wr_log[$];

   // ---------------- behavioural memory slave + protocol monitor ----------------
   task automatic slave_proc();
      int          cnt = 0;
      bit          pend = 1'b0;
      bit          wait_v;
      logic [31:0] pdata = '0;
      bit          p_req = 1'b0, p_wait = 1'b0, p_rst = 1'b1;
      logic [55:0] p_bus = '0;
      logic [55:0] bus_now;
      forever begin
         @(negedge clk);
         avm_if.readdatavalid = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt == 0) begin
               avm_if.readdatavalid = 1'b1;
               avm_if.readdata      = pdata;
               pend                 = 1'b0;
            end
         end
         bus_now = {avm_if.read, avm_if.write, avm_if.byteenable, avm_if.address, avm_if.writedata};
         if (p_req && p_wait && !p_rst) begin
            checks++;
            if (bus_now !== p_bus) begin
               errors++;
               $display("FAIL hold_stable: bus %h, held value %h", bus_now, p_bus);
            end
         end
         if (avm_if.read || avm_if.write) begin
            if (!reset) req_cycles++;
            checks++;
            if ((avm_if.read && avm_if.write) || avm_if.address[1:0] !== 2'b00 ||
                avm_if.byteenable !== 4'hF) begin
               errors++;
               $display("FAIL protocol: rd=%b wr=%b addr=%h be=%h, want single req, aligned, be=f",
                        avm_if.read, avm_if.write, avm_if.address, avm_if.byteenable);
            end
         end
         wait_v = (stall_pct != 0) && ($urandom_range(99, 0) < stall_pct);
         if (avm_if.write && stall_writes) wait_v = 1'b1;
         avm_if.waitrequest = wait_v;
         if (!wait_v && !reset && avm_if.read) begin
            rd_log.push_back(avm_if.address);
            pdata = mem[avm_if.address[16:2]];
            cnt   = $urandom_range(lat_max, 1);
            pend  = 1'b1;
         end
         if (!wait_v && !reset && avm_if.write) begin
            mem[avm_if.address[16:2]] = avm_if.writedata;
            wr_log.push_back(avm_if.address);
         end
         p_req  = avm_if.read || avm_if.write;
         p_wait = wait_v;
         p_rst  = reset;
         p_bus  = bus_now;
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_copy(input int s, input int d, input int l);
      for (int i = 0; i < l; i++) exp_mem[(d + i) % MEM_N] = exp_mem[(s + i) % MEM_N];
   endtask

   function automatic bit log_ok(input logic [16:0] q[$], input int base, input int l);
      if (q.size() != l) return 1'b0;
      for (int i = 0; i < l; i++)
         if (q[i] !== 17'(((base + i) % MEM_N) * 4)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int mem_diffs();
      int c = 0;
      for (int i = 0; i < MEM_N; i++) if (mem[i] !== exp_mem[i]) c++;
      return c;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic start_copy(input logic [14:0] s, input logic [14:0] d, input logic [14:0] l);
      @(posedge clk); #2;
      start = 1'b1; src_word = s; dst_word = d; len_words = l;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, want 1", done, n);
      end else begin
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: busy=%b, want 0", busy);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b one cycle later, want 0 0", done, busy);
         end
      end
   endtask

   task automatic run_checked(input string name, input int s, input int d, input int l,
                              output int n);
      rd_log.delete();
      wr_log.delete();
      exp_mem = mem;
      model_copy(s, d, l);
      start_copy(15'(s), 15'(d), 15'(l));
      wait_done(3000, n);
      checks++;
      if (words_done !== 15'(l)) begin
         errors++;
         $display("FAIL %s words_done: got %0d, want %0d", name, words_done, l);
      end
      checks++;
      if (mem_diffs() != 0) begin
         errors++;
         $display("FAIL %s memory: %0d words differ from model", name, mem_diffs());
      end
      checks++;
      if (!log_ok(rd_log, s, l) || !log_ok(wr_log, d, l)) begin
         errors++;
         $display("FAIL %s addr_seq: %0d reads %0d writes, want %0d ascending each",
                  name, rd_log.size(), wr_log.size(), l);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, avm_if.read, avm_if.write} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ctrl: busy/done/rd/wr=%b, want 0000",
                  {busy, done, avm_if.read, avm_if.write});
      end
      checks++;
      if (words_done !== '0 || avm_if.address !== '0 || avm_if.writedata !== '0 ||
          avm_if.byteenable !== '0) begin
         errors++;
         $display("FAIL reset_data: wd=%h addr=%h wdata=%h be=%h, want all 0",
                  words_done, avm_if.address, avm_if.writedata, avm_if.byteenable);
      end
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int          n;
      logic [31:0] a[4];
      stall_pct = 0;
      lat_max   = 1;
      for (int i = 0; i < 4; i++) begin
         a[i]        = $urandom;
         mem[16 + i] = a[i];
      end
      run_checked("basic", 'h010, 'h100, 4, n);
      checks++;
      if (n !== 13) begin
         errors++;
         $display("FAIL basic_latency: done after %0d clocks, want 13", n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[256 + i] !== a[i]) begin
            errors++;
            $display("FAIL basic_data[%0d]: got %h, want %h", i, mem[256 + i], a[i]);
         end
      end
   endtask

   task automatic test_len_zero();
      stall_pct = 0;
      rd_log.delete();
      wr_log.delete();
      req_cycles = 0;
      exp_mem = mem;
      start_copy(15'h0040, 15'h0080, 15'h0000);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0 || words_done !== '0) begin
         errors++;
         $display("FAIL len0_accept: busy=%b done=%b wd=%0d, want 1 0 0", busy, done, words_done);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL len0_done: done=%b busy=%b, want 1 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || req_cycles != 0 || mem_diffs() != 0) begin
         errors++;
         $display("FAIL len0_quiet: done=%b req_cycles=%0d, want 0 0", done, req_cycles);
      end
   endtask

   task automatic test_wrap();
      int          n;
      logic [16:0] exp_a[4];
      exp_a     = '{17'h1FFF8, 17'h1FFFC, 17'h00000, 17'h00004};
      stall_pct = 0;
      lat_max   = 1;
      run_checked("wrap", 'h7FFE, 'h0300, 4, n);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_log.size() <= i || rd_log[i] !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_addr[%0d]: got %h, want %h", i,
                     (rd_log.size() > i) ? rd_log[i] : 17'h0, exp_a[i]);
         end
      end
   endtask

   task automatic test_stalls();
      int n, s, d, l;
      stall_pct = 50;
      lat_max   = 5;
      for (int k = 0; k < 6; k++) begin
         s = $urandom_range(MEM_N - 1, 0);
         d = (s + $urandom_range(40, 0)) % MEM_N;
         if (k % 2 == 1) d = $urandom_range(MEM_N - 1, 0);
         l = $urandom_range(20, 1);
         run_checked("stalls", s, d, l, n);
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      stall_pct = 30;
      lat_max   = 3;
      rd_log.delete();
      wr_log.delete();
      exp_mem = mem;
      model_copy('h0500, 'h0600, 6);
      start_copy(15'h0500, 15'h0600, 15'd6);
      repeat (3) @(posedge clk);
      start_copy(15'h0700, 15'h0800, 15'd9);
      wait_done(3000, n);
      checks++;
      if (words_done !== 15'd6 || mem_diffs() != 0 || !log_ok(rd_log, 'h0500, 6)) begin
         errors++;
         $display("FAIL busy_start: wd=%0d diffs=%0d reads=%0d, want 6 0 6",
                  words_done, mem_diffs(), rd_log.size());
      end
   endtask

   task automatic test_reset_abort();
      int          n;
      logic [31:0] orig2;
      stall_pct = 0;
      lat_max   = 1;
      orig2     = mem['h2002];
      exp_mem   = mem;
      model_copy('h1000, 'h2000, 2);
      start_copy(15'h1000, 15'h2000, 15'd5);
      n = 0;
      while (words_done !== 15'd2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      stall_writes = 1'b1;
      while (avm_if.write !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (avm_if.write !== 1'b1 || words_done !== 15'd2) begin
         errors++;
         $display("FAIL abort_reach: write=%b wd=%0d, want 1 2", avm_if.write, words_done);
      end
      @(posedge clk); #2;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, avm_if.read, avm_if.write, avm_if.byteenable} !== 8'h00 ||
          words_done !== '0 || avm_if.address !== '0 || avm_if.writedata !== '0) begin
         errors++;
         $display("FAIL abort_outputs: busy=%b rd=%b wr=%b wd=%0d addr=%h, want all 0",
                  busy, avm_if.read, avm_if.write, words_done, avm_if.address);
      end
      @(posedge clk); #2;
      reset        = 1'b0;
      stall_writes = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (mem_diffs() != 0 || mem['h2002] !== orig2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_memory: diffs=%0d dst+2=%h busy=%b, want 0 %h 0",
                  mem_diffs(), mem['h2002], busy, orig2);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      stall_pct = 0;
      lat_max   = 1;
      run_checked("b2b_a", 'h3000, 'h3100, 3, n);
      run_checked("b2b_b", 'h3100, 'h3102, 5, n);
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL b2b_latency: done after %0d clocks, want 16", n);
      end
   endtask

   initial begin
      avm_if.readdata      = '0;
      avm_if.readdatavalid = 1'b0;
      avm_if.waitrequest   = 1'b0;
      for (int i = 0; i < MEM_N; i++) mem[i] = $urandom;
      fork
         slave_proc();
      join_none
      test_reset();
      test_basic();
      test_len_zero();
      test_wrap();
      test_stalls();
      test_start_while_busy();
      test_reset_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
